// File: rtl/wb_design_pkg.sv
// Shared register offsets, field positions and sequencer states for the design-select controller.
// Constants only; no timing or backpressure of its own.
package wb_design_pkg;

  localparam logic [3:0] OFF_SEL    = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_CLR    = 4'hC;

  localparam int CTRL_RUN_BIT  = 0;
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;
  localparam int STAT_SEL_LSB  = 8;
  localparam int CLR_ERR_BIT   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_HOLD,
    ST_SWITCH,
    ST_RELEASE
  } state_t;

endpackage

// File: rtl/wb_design_ctrl_if.sv
// Wishbone classic slave bus bundle; master drives strobes/address/data, slave returns ack/data.
// No storage; the slave acks one cycle after a request and never on consecutive cycles.
interface wb_design_ctrl_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/wb_slave_if.sv
// Wishbone decode, registered ack/read data and byte-0 write strobes for the controller registers.
// Ack and read data one cycle after the request; a held request is acked every other cycle.
module wb_slave_if
  import wb_design_pkg::*;
#(
  parameter int          SEL_W     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_design_ctrl_if.slave  wb,
  input  logic [SEL_W-1:0] pend_sel,
  input  logic [SEL_W-1:0] act_sel,
  input  logic             run,
  input  logic             busy,
  input  logic             err,
  output logic             wr_sel,
  output logic             wr_ctrl,
  output logic             wr_clr,
  output logic [7:0]       wr_byte
);

  logic        access;
  logic        hit;
  logic        wr_lane0;
  logic [3:0]  off;
  logic [31:0] rd_dat;
  logic        unused_bits;

  // Suppressing a request while ack is high gives the mandatory gap between acks.
  assign access   = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o;
  assign hit      = access & (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign off      = {wb.wbs_adr_i[3:2], 2'b00};
  assign wr_lane0 = hit & wb.wbs_we_i & wb.wbs_sel_i[0];

  assign wr_sel  = wr_lane0 & (off == OFF_SEL);
  assign wr_ctrl = wr_lane0 & (off == OFF_CTRL);
  assign wr_clr  = wr_lane0 & (off == OFF_CLR);
  assign wr_byte = wb.wbs_dat_i[7:0];

  assign unused_bits = ^{wb.wbs_adr_i[1:0], wb.wbs_dat_i[31:8], wb.wbs_sel_i[3:1]};

  always_comb begin
    rd_dat = '0;
    case (off)
      OFF_SEL:  rd_dat[SEL_W-1:0] = pend_sel;
      OFF_CTRL: rd_dat[CTRL_RUN_BIT] = run;
      OFF_STATUS: begin
        rd_dat[STAT_BUSY_BIT]             = busy;
        rd_dat[STAT_ERR_BIT]              = err;
        rd_dat[STAT_SEL_LSB +: SEL_W]     = act_sel;
      end
      default:  rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= access;
      wb.wbs_dat_o <= (hit & ~wb.wbs_we_i) ? rd_dat : '0;
    end
  end

endmodule

// File: rtl/wb_design_ctrl.sv
// Selects the active user design: drains IOs, holds design reset RST_CYCLES cycles, switches, releases.
// Register access acks in one cycle; SEL writes arriving mid-sequence are dropped and flag ERR.
module wb_design_ctrl
  import wb_design_pkg::*;
#(
  parameter int          NUM_DESIGNS = 16,
  parameter int          SEL_W       = $clog2(NUM_DESIGNS),
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          RST_CYCLES  = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  wb_design_ctrl_if.slave  wb,
  output logic [SEL_W-1:0] des_sel_o,
  output logic             des_rst_no,
  output logic             io_force_oeb_o
);

  localparam int              CNT_W    = $clog2(RST_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] pend_sel;
  logic             run;
  logic             run_seen;
  logic             err;
  logic             busy;
  logic             wr_sel;
  logic             wr_ctrl;
  logic             wr_clr;
  logic [7:0]       wr_byte;
  logic             run_nxt;
  logic             sel_take;
  logic             io_release;

  assign busy       = (state != ST_IDLE);
  assign run_nxt    = wr_ctrl ? wr_byte[CTRL_RUN_BIT] : run;
  assign sel_take   = wr_sel & ~busy;
  // IOs stay forced to inputs until software has enabled a design at least once.
  assign io_release = run_seen | run_nxt;

  wb_slave_if #(
    .SEL_W     (SEL_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_slave (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .wb       (wb),
    .pend_sel (pend_sel),
    .act_sel  (des_sel_o),
    .run      (run),
    .busy     (busy),
    .err      (err),
    .wr_sel   (wr_sel),
    .wr_ctrl  (wr_ctrl),
    .wr_clr   (wr_clr),
    .wr_byte  (wr_byte)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      pend_sel       <= '0;
      run            <= 1'b0;
      run_seen       <= 1'b0;
      err            <= 1'b0;
      des_sel_o      <= '0;
      des_rst_no     <= 1'b0;
      io_force_oeb_o <= 1'b1;
    end else begin
      run      <= run_nxt;
      run_seen <= io_release;
      if (wr_sel & busy) begin
        err <= 1'b1;
      end else if (wr_clr & wr_byte[CLR_ERR_BIT]) begin
        err <= 1'b0;
      end
      if (sel_take) begin
        pend_sel <= wr_byte[SEL_W-1:0];
      end

      case (state)
        ST_IDLE: begin
          des_rst_no <= run_nxt;
          if (sel_take) begin
            state          <= ST_DRAIN;
            io_force_oeb_o <= 1'b1;
          end else begin
            io_force_oeb_o <= ~io_release;
          end
        end
        ST_DRAIN: begin
          state      <= ST_HOLD;
          des_rst_no <= 1'b0;
          cnt        <= '0;
        end
        ST_HOLD: begin
          if (cnt == CNT_LAST) begin
            state     <= ST_SWITCH;
            cnt       <= '0;
            des_sel_o <= pend_sel;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SWITCH: begin
          state          <= ST_RELEASE;
          des_rst_no     <= run_nxt;
          io_force_oeb_o <= ~io_release;
        end
        ST_RELEASE: begin
          state          <= ST_IDLE;
          des_rst_no     <= run_nxt;
          io_force_oeb_o <= ~io_release;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_design_ctrl.md
WB_DESIGN_CTRL -- requirements
Module: wb_design_ctrl

Interface
REQ-001 SHALL have parameter NUM_DESIGNS, default 16, number of selectable designs (power of 2, >=2).
REQ-002 SHALL have parameter SEL_W, default $clog2(NUM_DESIGNS), select width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address.
REQ-004 SHALL have parameter RST_CYCLES, default 8, design-reset hold length in cycles (>=2).
REQ-005 wb_clk_i  in  1  sole clock; one clock domain; reset asynchronous, active-low.
REQ-006 wb_rst_ni  in  1  asynchronous active-low reset.
REQ-007 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
REQ-008 wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data; wbs_sel_i  in  4  byte enables.
REQ-009 wbs_ack_o  out  1  ack; wbs_dat_o  out  32  read data.
REQ-010 des_sel_o  out  SEL_W  active design index to the IO mux.
REQ-011 des_rst_no  out  1  active-low reset to the active design.
REQ-012 io_force_oeb_o  out  1  when 1, IO mux drives all io_oeb high (inputs).

Function
REQ-013 Register map (offset from BASE_ADDR): 0x0 SEL (RW, bits[SEL_W-1:0]); 0x4 CTRL (RW, bit0 RUN); 0x8 STATUS (RO: bit0 BUSY, bit1 ERR sticky, bits[8+SEL_W-1:8] active sel); 0xC CLR (WO, bit1=1 clears ERR).
REQ-014 Access decode: cyc&stb and adr[31:4]==BASE_ADDR[31:4]; other addresses ack with read data 0, writes ignored.
REQ-015 wbs_ack_o SHALL assert exactly one cycle after a decoded request and SHALL be low the following cycle (no back-to-back ack; a held request acks every other cycle).
REQ-016 wbs_dat_o SHALL be valid only in the ack cycle and 0 otherwise; unused bits read 0.
REQ-017 Writes honour wbs_sel_i per byte; SEL and CTRL fields live in byte 0.
REQ-018 FSM states IDLE, DRAIN, HOLD, SWITCH, RELEASE.
REQ-019 IDLE: a write to SEL with sel[0]=1 captures pending sel and enters DRAIN; BUSY=1 from the cycle after capture.
REQ-020 DRAIN (1 cycle): io_force_oeb_o=1 -> HOLD.
REQ-021 HOLD: des_rst_no=0 for exactly RST_CYCLES cycles (counter), io_force_oeb_o=1 -> SWITCH.
REQ-022 SWITCH (1 cycle): des_sel_o <= pending sel, reset still held -> RELEASE.
REQ-023 RELEASE (1 cycle): io_force_oeb_o=0; des_rst_no=RUN -> IDLE, BUSY=0.
REQ-024 In IDLE, des_rst_no SHALL equal CTRL.RUN; clearing RUN asserts design reset next cycle without switching.
REQ-025 SEL write while BUSY SHALL be ignored and set ERR; write of same value as active sel still runs full sequence.
REQ-026 SEL write and CLR in the same access are impossible (distinct addresses); ERR set and clear same cycle: set wins.
REQ-027 Readback of SEL returns last accepted pending value; STATUS active sel returns des_sel_o.

Reset
REQ-028 On wb_rst_ni low (async): FSM IDLE, des_sel_o=0, pending sel=0, RUN=0, ERR=0, counter=0, wbs_ack_o=0, wbs_dat_o=0, des_rst_no=0, io_force_oeb_o=1.
REQ-029 io_force_oeb_o SHALL deassert only after first RUN=1 write following reset; reset mid-sequence returns to REQ-028 values immediately.
REQ-030 Reset deassertion is synchronised by the caller; block assumes synchronous release.

Structure
REQ-031 Shared package wb_design_pkg SHALL hold register offsets, STATUS bit positions, and FSM state enum.
REQ-032 One sub-module wb_slave_if (decode, ack, byte-lane write strobes, read mux) is natural; FSM and counter stay in the top.

Verification
REQ-033 Reset, write CTRL=1 -> des_rst_no=1, io_force_oeb_o=0 next cycle; STATUS reads 0x0.
REQ-034 RUN=1, write SEL=5 -> BUSY; des_rst_no low 8+1 cycles; des_sel_o=5 at SWITCH; STATUS reads 0x0500 after.
REQ-035 Write SEL=3 during HOLD -> ignored, STATUS bit1=1, des_sel_o unchanged by it; CLR 0x2 -> bit1=0.
REQ-036 Held cyc/stb for 6 cycles -> exactly 3 acks, alternating cycles; unmapped address read -> 0, ack given.
REQ-037 Assert wb_rst_ni mid-HOLD -> all outputs at REQ-028 values same cycle; sequence not resumed.
REQ-038 Write SEL with wbs_sel_i=4'b1110 -> no capture, FSM stays IDLE.
